poly_add_seq: RTL and testbench
===============================

# poly_add_seq

Sequencer that computes one coefficient-wise modular polynomial sum c[i] = (a[i] + b[i]) mod q for i = 0..N-1. It streams operands from two coefficient RAMs, feeds them through a single shared modular-add datapath, and writes results to a third RAM. It sits between the FHE top-level command logic (start/done) and the polynomial coefficient memories.

## Interface
- DATA_WIDTH, 16: coefficient and modulus width.
- N, 256: coefficients per polynomial, ≥1.
- ADDR_WIDTH, $clog2(N) (min 1): RAM address width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- q  in  DATA_WIDTH  modulus; latched at start accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- a_rd_en, b_rd_en  out  1  operand read strobes.
- a_addr, b_addr  out  ADDR_WIDTH  operand read addresses (always equal).
- a_rdata, b_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after the rd_en cycle.
- c_wr_en  out  1  result write strobe.
- c_addr  out  ADDR_WIDTH  result address.
- c_wdata  out  DATA_WIDTH  result coefficient.
- op_sub  in  1  only with POLY_SUB_EN; latched at start accept.

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: start=1 latches q (and op_sub) into q_r and resets rd counter to 0, then goes to RUN. A start outside IDLE is ignored, including in DONE.
- RUN: assert a_rd_en=b_rd_en=1 with addr=rd_cnt and increment rd_cnt. After issuing addr N-1, go to DRAIN.
- DRAIN: lasts exactly 2 cycles with no reads, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pipeline stage 1, the read cycle: valid_1 and addr_1 register the issued address.
- Pipeline stage 2, the data cycle: sum = a_rdata + b_rdata in DATA_WIDTH+1 bits. res = (sum ≥ q_r) ? sum − q_r : sum, truncated to DATA_WIDTH. res, addr and valid are registered and drive c_wdata, c_addr and c_wr_en.
- Operands must be < q_r. With out-of-range operands the result is defined by the formula above (a single conditional subtract) and is not checked.
- q_r = 0 is legal. Every sum is then ≥ q_r, so the result is sum truncated.
- Writes occur in ascending address order, exactly N writes per operation, no gaps.

## Timing
- Start accepted at edge 0. Read k is issued in cycle k+1 and written in cycle k+3.
- Last write is in cycle N+2. done is high in cycle N+3. Total N+3 cycles from accept to done.
- busy is high in cycles 1..N+2, i.e. RUN and DRAIN. busy is low in DONE.
- Back-to-back: the earliest next start is sampled in the first IDLE cycle after DONE.
- Reset, asynchronous: state=IDLE. busy, done, a_rd_en, b_rd_en and c_wr_en are 0. All addresses, c_wdata, q_r and the counters are 0.
- Reset mid-operation aborts immediately. No further writes occur and done never fires for the aborted run.
- q and op_sub changing after accept have no effect until the next start.
- N=1: a single read in cycle 1, a write in cycle 3, done in cycle 4.

## Configuration
- POLY_SUB_EN defined: the op_sub port exists. With op_sub_r=1, stage 2 computes diff = a − b in DATA_WIDTH+1 bits, and res = (a < b) ? diff + q_r : diff, truncated. With op_sub_r=0 the block adds as described above.
- POLY_SUB_EN undefined: no op_sub port, add only. Behaviour is identical to op_sub=0.

## Structure
- Package poly_pkg holds:
  - DATA_WIDTH default;
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the coefficient typedef logic [DATA_WIDTH-1:0].
- Sub-module mod_addsub is purely combinational.
  - Inputs: a, b, q and sub (sub present only under POLY_SUB_EN).
  - Output: res.
- The FSM, counters and pipeline registers live in poly_add_seq.

## Test plan
- Basic add: N=4, q=17, a={1,16,8,0}, b={2,1,9,0} → writes c={3,0,0,0} to addr 0..3 in cycles 3..6; done in cycle 7; busy high in cycles 1..6.
- Boundary: q=65535, a=b=65534 → c=65533 (DATA_WIDTH+1 intermediate). q=0, a=b=40000 → c=14464 (80000 truncated to 16 bits).
- Start while busy: pulse start at cycle 3 with q=5 → ignored; results still use the original q; exactly N writes.
- Reset at cycle 2 of an N=256 run → all outputs 0 asynchronously; no c_wr_en and no done afterwards. A new start then completes normally in 259 cycles.
- Back-to-back: start held high continuously → second accept in the first IDLE after DONE; the two runs are separated by exactly one non-busy DONE cycle plus that IDLE cycle.
- POLY_SUB_EN with op_sub=1, q=17, a=3, b=5 → c=15; a=5, b=3 → c=2.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types and helpers for the polynomial coefficient sequencer.
// The optional POLY_SUB_EN build adds modular subtraction to the datapath.
package poly_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] coeff_t;

  // A single-entry RAM still needs a one-bit address bus.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_addsub.sv
// Combinational single-step modular adder (and subtractor when POLY_SUB_EN is defined).
// Operands are expected to be below q; out-of-range inputs get one conditional correction only.
module mod_addsub #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] q,
`ifdef POLY_SUB_EN
  input  logic                  sub,
`endif
  output logic [DATA_WIDTH-1:0] res
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] res_add;

  // One extra bit keeps the carry so the compare against q sees the true sum.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign res_add = (sum >= {1'b0, q}) ? DATA_WIDTH'(sum - {1'b0, q}) : sum[DATA_WIDTH-1:0];

`ifdef POLY_SUB_EN
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] res_sub;

  assign diff    = {1'b0, a} - {1'b0, b};
  assign res_sub = (a < b) ? DATA_WIDTH'(diff + {1'b0, q}) : diff[DATA_WIDTH-1:0];
  assign res     = sub ? res_sub : res_add;
`else
  assign res     = res_add;
`endif

endmodule

// File: rtl/poly_add_seq.sv
// Streams N coefficient pairs from two RAMs through mod_addsub and writes the results to a third RAM.
// Defining POLY_SUB_EN adds the op_sub port and selects subtraction per operation.
module poly_add_seq
  import poly_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = 256,
  parameter int ADDR_WIDTH = addr_bits(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] q,
`ifdef POLY_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  a_rd_en,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  c_wr_en,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  rd_en_q;
  logic                  drain_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] q_q;
`ifdef POLY_SUB_EN
  logic                  sub_q;
`endif

  logic                  valid1_q;
  logic [ADDR_WIDTH-1:0] addr1_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] c_addr_q;
  logic [DATA_WIDTH-1:0] c_wdata_q;
  logic [DATA_WIDTH-1:0] res_d;

  // Control: every output is a register so RAM strobes leave the block glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      drain_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
`ifdef POLY_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            q_q     <= q;
`ifdef POLY_SUB_EN
            sub_q   <= op_sub;
`endif
          end
        end
        RUN: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          // Two cycles let the final read pass through both pipeline stages.
          if (drain_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  mod_addsub #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mod_addsub (
    .a  (a_rdata),
    .b  (b_rdata),
    .q  (q_q),
`ifdef POLY_SUB_EN
    .sub(sub_q),
`endif
    .res(res_d)
  );

  // Stage 1 tracks the address in flight; stage 2 captures the result once RAM data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q  <= 1'b0;
      addr1_q   <= '0;
      wr_en_q   <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
    end else begin
      valid1_q <= rd_en_q;
      addr1_q  <= cnt_q;
      wr_en_q  <= valid1_q;
      if (valid1_q) begin
        c_addr_q  <= addr1_q;
        c_wdata_q <= res_d;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_rd_en = rd_en_q;
  assign b_rd_en = rd_en_q;
  assign a_addr  = cnt_q;
  assign b_addr  = cnt_q;
  assign c_wr_en = wr_en_q;
  assign c_addr  = c_addr_q;
  assign c_wdata = c_wdata_q;

endmodule

// File: tb/tb_poly_add_seq.sv
// Directed bench: a 4-coefficient instance for timing/arithmetic and a 256-coefficient instance for abort/restart.
// Subtraction vectors run only when POLY_SUB_EN is defined.
module tb_poly_add_seq;

  localparam int DW  = 16;
  localparam int NS  = 4;
  localparam int NB  = 256;
  localparam int AWS = 2;
  localparam int AWB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Small instance
  logic           rst_n, start;
  logic [DW-1:0]  q;
  logic           op_sub;
  logic           busy, done, a_rd_en, b_rd_en, c_wr_en;
  logic [AWS-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0]  a_rdata, b_rdata, c_wdata;
  logic [DW-1:0]  a_mem [NS];
  logic [DW-1:0]  b_mem [NS];
  logic [DW-1:0]  c_exp [NS];

  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= a_mem[a_addr];
    if (b_rd_en) b_rdata <= b_mem[b_addr];
  end

  poly_add_seq #(.DATA_WIDTH(DW), .N(NS)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q),
`ifdef POLY_SUB_EN
    .op_sub(op_sub),
`endif
    .busy(busy), .done(done), .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  // Large instance
  logic           bg_rst_n, bg_start;
  logic [DW-1:0]  bg_q;
  logic           bg_op_sub;
  logic           bg_busy, bg_done, bg_a_rd_en, bg_b_rd_en, bg_c_wr_en;
  logic [AWB-1:0] bg_a_addr, bg_b_addr, bg_c_addr;
  logic [DW-1:0]  bg_a_rdata, bg_b_rdata, bg_c_wdata;
  logic [DW-1:0]  bg_a_mem [NB];
  logic [DW-1:0]  bg_b_mem [NB];

  always @(posedge clk) begin
    if (bg_a_rd_en) bg_a_rdata <= bg_a_mem[bg_a_addr];
    if (bg_b_rd_en) bg_b_rdata <= bg_b_mem[bg_b_addr];
  end

  poly_add_seq #(.DATA_WIDTH(DW), .N(NB)) u_big (
    .clk(clk), .rst_n(bg_rst_n), .start(bg_start), .q(bg_q),
`ifdef POLY_SUB_EN
    .op_sub(bg_op_sub),
`endif
    .busy(bg_busy), .done(bg_done), .a_rd_en(bg_a_rd_en), .b_rd_en(bg_b_rd_en),
    .a_addr(bg_a_addr), .b_addr(bg_b_addr), .a_rdata(bg_a_rdata), .b_rdata(bg_b_rdata),
    .c_wr_en(bg_c_wr_en), .c_addr(bg_c_addr), .c_wdata(bg_c_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full 4-coefficient operation with cycle-exact checks; cycle k counts from the accept edge.
  task automatic run4(input logic [DW-1:0] qv, input logic sub, input bit mid, input string tag);
    $display("run %s q=%0d op_sub=%0d mid_start=%0d", tag, qv, sub, mid);
    @(negedge clk);
    start  = 1'b1;
    q      = qv;
    op_sub = sub;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'((k >= 1 && k <= 6) ? 1 : 0));
      chk($sformatf("%s.done@%0d", tag, k), 32'(done), 32'((k == 7) ? 1 : 0));
      chk($sformatf("%s.rd_en@%0d", tag, k), 32'({a_rd_en, b_rd_en}), 32'((k <= 4) ? 3 : 0));
      if (k <= 4) begin
        chk($sformatf("%s.a_addr@%0d", tag, k), 32'(a_addr), 32'(k - 1));
        chk($sformatf("%s.b_addr@%0d", tag, k), 32'(b_addr), 32'(k - 1));
      end
      chk($sformatf("%s.wr_en@%0d", tag, k), 32'(c_wr_en), 32'((k >= 3 && k <= 6) ? 1 : 0));
      if (k >= 3 && k <= 6) begin
        chk($sformatf("%s.c_addr@%0d", tag, k), 32'(c_addr), 32'(k - 3));
        chk($sformatf("%s.c_wdata@%0d", tag, k), 32'(c_wdata), 32'(c_exp[k-3]));
      end
      // Inputs wiggle after accept to prove they were latched.
      start  = mid && (k == 3 || k == 7);
      q      = mid ? 16'd5 : ~qv;
      op_sub = ~sub;
    end
    start = 1'b0;
  endtask

  int wr_cnt, done_cnt, bad_cnt, done_cyc;
  logic [DW-1:0] exp_v;

  initial begin
    rst_n = 1'b1; bg_rst_n = 1'b1;
    start = 1'b0; q = '0; op_sub = 1'b0;
    bg_start = 1'b0; bg_q = '0; bg_op_sub = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bg_a_mem[i] = DW'(i);
      bg_b_mem[i] = DW'(i);
    end

    #2;
    rst_n = 1'b0; bg_rst_n = 1'b0;
    #1;
    $display("reset check");
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.rd_en", 32'({a_rd_en, b_rd_en}), 32'd0);
    chk("rst.addr", 32'({a_addr, b_addr, c_addr}), 32'd0);
    chk("rst.wr_en", 32'(c_wr_en), 32'd0);
    chk("rst.c_wdata", 32'(c_wdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; bg_rst_n = 1'b1;

    a_mem = '{16'd1, 16'd16, 16'd8, 16'd0};
    b_mem = '{16'd2, 16'd1, 16'd9, 16'd0};
    c_exp = '{16'd3, 16'd0, 16'd0, 16'd0};
    run4(16'd17, 1'b0, 1'b0, "basic");

    a_mem = '{16'd65534, 16'd0, 16'd1, 16'd65534};
    b_mem = '{16'd65534, 16'd0, 16'd65533, 16'd1};
    c_exp = '{16'd65533, 16'd0, 16'd65534, 16'd0};
    run4(16'd65535, 1'b0, 1'b0, "qmax");

    a_mem = '{16'd40000, 16'd0, 16'd1, 16'd65535};
    b_mem = '{16'd40000, 16'd0, 16'd2, 16'd1};
    c_exp = '{16'd14464, 16'd0, 16'd3, 16'd0};
    run4(16'd0, 1'b0, 1'b0, "qzero");

    a_mem = '{16'd5, 16'd10, 16'd15, 16'd16};
    b_mem = '{16'd5, 16'd10, 16'd3, 16'd16};
    c_exp = '{16'd10, 16'd3, 16'd1, 16'd15};
    run4(16'd17, 1'b0, 1'b1, "start_busy");

`ifdef POLY_SUB_EN
    a_mem = '{16'd3, 16'd5, 16'd0, 16'd16};
    b_mem = '{16'd5, 16'd3, 16'd0, 16'd0};
    c_exp = '{16'd15, 16'd2, 16'd0, 16'd16};
    run4(16'd17, 1'b1, 1'b0, "sub");
`endif

    // Back-to-back with start held high.
    a_mem = '{16'd1, 16'd16, 16'd8, 16'd0};
    b_mem = '{16'd2, 16'd1, 16'd9, 16'd0};
    $display("run b2b q=17 start held");
    @(negedge clk);
    start = 1'b1; q = 16'd17; op_sub = 1'b0;
    wr_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("b2b.busy@%0d", k), 32'(busy),
          32'(((k >= 1 && k <= 6) || (k >= 9 && k <= 14)) ? 1 : 0));
      chk($sformatf("b2b.done@%0d", k), 32'(done), 32'((k == 7 || k == 15) ? 1 : 0));
      if (c_wr_en) wr_cnt++;
      if (k == 9) start = 1'b0;
    end
    chk("b2b.writes", 32'(wr_cnt), 32'd8);

    // Abort a 256-coefficient run in cycle 2, then restart it.
    $display("run big_abort q=500");
    @(negedge clk);
    bg_start = 1'b1; bg_q = 16'd500;
    @(negedge clk);
    bg_start = 1'b0;
    @(negedge clk);
    chk("abort.pre_busy", 32'(bg_busy), 32'd1);
    bg_rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(bg_busy), 32'd0);
    chk("abort.rd_en", 32'({bg_a_rd_en, bg_b_rd_en}), 32'd0);
    chk("abort.a_addr", 32'(bg_a_addr), 32'd0);
    chk("abort.wr_en", 32'(bg_c_wr_en), 32'd0);
    chk("abort.c_addr", 32'(bg_c_addr), 32'd0);
    chk("abort.done", 32'(bg_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bg_rst_n = 1'b1;
    wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bg_c_wr_en) wr_cnt++;
      if (bg_done) done_cnt++;
    end
    chk("abort.writes_after", 32'(wr_cnt), 32'd0);
    chk("abort.done_after", 32'(done_cnt), 32'd0);

    $display("run big_restart q=500");
    @(negedge clk);
    bg_start = 1'b1; bg_q = 16'd500;
    wr_cnt = 0; bad_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      bg_start = 1'b0;
      bg_q = 16'd7;
      if (bg_c_wr_en) begin
        exp_v = (2 * wr_cnt >= 500) ? DW'(2 * wr_cnt - 500) : DW'(2 * wr_cnt);
        if (bg_c_addr !== AWB'(wr_cnt)) bad_cnt++;
        if (bg_c_wdata !== exp_v) bad_cnt++;
        wr_cnt++;
      end
      if (bg_done) begin
        done_cyc = k;
        break;
      end
    end
    chk("restart.done_cycle", 32'(done_cyc), 32'd259);
    chk("restart.writes", 32'(wr_cnt), 32'd256);
    chk("restart.data_errs", 32'(bad_cnt), 32'd0);
    chk("restart.busy_at_done", 32'(bg_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
